// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) helpers, MixColumns column function
// and the FSM state type for the iterative encryption core.
package aes_pkg;

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned ROUND_W    = 4;
    localparam int unsigned LAST_ROUND = 10;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aesState_t;

    // Entry i lives at bits [(255-i)*8 +: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    // Column bytes a0..a3 run from MSB to LSB.
    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] iState,
    input  logic [BLOCK_W-1:0] iRoundKey,
    input  logic               iLast,
    output logic [BLOCK_W-1:0] oState
);

    logic [BLOCK_W-1:0] shifted;
    logic [BLOCK_W-1:0] mixed;

    // Byte k = s(k%4, k/4) sits at bits [127-8k -: 8]; row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        mixed   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8 * (r + 4 * c) -: 8] =
                    sbox(iState[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mixColumn(shifted[127 - 32 * c -: 32]);
        end
        oState = (iLast ? shifted : mixed) ^ iRoundKey;
    end

endmodule

// File: rtl/aes_encryp_iter.sv
// Iterative AES-128 encryption core: one round per cycle, on-the-fly key expansion.
// Optional feature macro AES_ENC_ZEROIZE_EN: clear datapath on output handshake and gate oCiphertext.
module aes_encryp_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iValid,
    output logic               oReady,
    input  logic [BLOCK_W-1:0] iKey,
    input  logic [BLOCK_W-1:0] iPlaintext,
    output logic               oValid,
    input  logic               iReady,
    output logic [BLOCK_W-1:0] oCiphertext
);

    aesState_t          state;
    aesState_t          nextState;
    logic [BLOCK_W-1:0] stateReg;
    logic [BLOCK_W-1:0] keyReg;
    logic [7:0]         rcon;
    logic [ROUND_W-1:0] rnd;

    logic [BLOCK_W-1:0] roundKey;
    logic [BLOCK_W-1:0] roundOut;
    logic [31:0]        w0, w1, w2, w3, t, nw0, nw1, nw2, nw3;
    logic               rndValid;
    logic               lastRound;
    logic               accept;
    logic               roundEn;
    logic               outHandshake;

    assign rndValid     = (rnd != '0) && (rnd <= ROUND_W'(LAST_ROUND));
    assign lastRound    = (rnd == ROUND_W'(LAST_ROUND));
    assign accept       = (state == IDLE) && iValid;
    assign roundEn      = (state == ROUND) && rndValid;
    assign outHandshake = (state == DONE) && iReady;

    // Next round key from the current key register and rcon.
    always_comb begin
        {w0, w1, w2, w3} = keyReg;
        t        = subWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        nw0      = w0 ^ t;
        nw1      = w1 ^ nw0;
        nw2      = w2 ^ nw1;
        nw3      = w3 ^ nw2;
        roundKey = {nw0, nw1, nw2, nw3};
    end

    aes_enc_round uRound (
        .iState    (stateReg),
        .iRoundKey (roundKey),
        .iLast     (lastRound),
        .oState    (roundOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iValid) nextState = ROUND;
            ROUND: begin
                if (!rndValid)     nextState = IDLE;
                else if (lastRound) nextState = DONE;
            end
            DONE:    if (iReady) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        oReady = (state == IDLE);
        oValid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= '0;
            keyReg   <= '0;
            rcon     <= '0;
            rnd      <= '0;
        end else if (accept) begin
            stateReg <= iPlaintext ^ iKey;
            keyReg   <= iKey;
            rcon     <= RCON_INIT;
            rnd      <= ROUND_W'(1);
        end else if (roundEn) begin
            stateReg <= roundOut;
            keyReg   <= roundKey;
            rcon     <= xtime(rcon);
            rnd      <= rnd + ROUND_W'(1);
`ifdef AES_ENC_ZEROIZE_EN
        end else if (outHandshake) begin
            stateReg <= '0;
            keyReg   <= '0;
            rcon     <= '0;
`endif
        end
    end

`ifdef AES_ENC_ZEROIZE_EN
    assign oCiphertext = oValid ? stateReg : '0;
`else
    assign oCiphertext = stateReg;
    logic unusedHandshake;
    assign unusedHandshake = outHandshake;
`endif

endmodule

// File: tb/tb_aes_encryp_iter.sv
// Directed self-checking bench for aes_encryp_iter using FIPS-197 vectors.
module tb_aes_encryp_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iValid;
    logic         oReady;
    logic [127:0] iKey;
    logic [127:0] iPlaintext;
    logic         oValid;
    logic         iReady;
    logic [127:0] oCiphertext;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_encryp_iter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iValid      (iValid),
        .oReady      (oReady),
        .iKey        (iKey),
        .iPlaintext  (iPlaintext),
        .oValid      (oValid),
        .iReady      (iReady),
        .oCiphertext (oCiphertext)
    );

    always #5 clk = ~clk;

    // Present one block, then scramble inputs and count cycles until oValid (-1 on timeout).
    task automatic startBlock(input logic [127:0] k, input logic [127:0] p, output int lat);
        @(negedge clk);
        iKey       = k;
        iPlaintext = p;
        iValid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iValid     = 1'b0;
        iKey       = {$urandom(), $urandom(), $urandom(), $urandom()};
        iPlaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (oValid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; iValid = 1'b0; iReady = 1'b0; iKey = '0; iPlaintext = '0;
        repeat (3) @(negedge clk);
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_oReady got=%b exp=1", oReady); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_oValid got=%b exp=0", oValid); end
        checks++; if (oCiphertext !== 128'h0) begin errors++; $display("FAIL reset_ct got=%h exp=0", oCiphertext); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL post_reset_oReady got=%b exp=1", oReady); end
    endtask

    task automatic test_fips_b;
        int lat;
        iReady = 1'b0;
        startBlock(KEY_B, PT_B, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL appB_latency got=%0d exp=10", lat); end
        checks++; if (oCiphertext !== CT_B) begin errors++; $display("FAIL appB_ct got=%h exp=%h", oCiphertext, CT_B); end
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL appB_oReady_done got=%b exp=0", oReady); end
    endtask

    task automatic test_back_pressure;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL bp_oValid cyc=%0d got=%b exp=1", i, oValid); end
            checks++; if (oCiphertext !== CT_B) begin errors++; $display("FAIL bp_ct cyc=%0d got=%h exp=%h", i, oCiphertext, CT_B); end
        end
        iReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL bp_release_oReady got=%b exp=1", oReady); end
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL bp_release_oValid got=%b exp=0", oValid); end
    endtask

    task automatic test_busy_rejection;
        int lat;
        iReady = 1'b1;
        @(negedge clk);
        iKey = KEY_C; iPlaintext = PT_C; iValid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 10) begin
                checks++; if (oReady !== 1'b0 || oValid !== 1'b0) begin
                    errors++; $display("FAIL busy_round k=%0d oReady=%b oValid=%b exp=0/0", k, oReady, oValid);
                end
            end else if (k == 10) begin
                checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL busy_oValid got=%b exp=1", oValid); end
                checks++; if (oCiphertext !== CT_C) begin errors++; $display("FAIL appC_ct got=%h exp=%h", oCiphertext, CT_C); end
            end else begin
                checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL busy_idle_oReady got=%b exp=1", oReady); end
            end
            if (k == 11) begin
                iKey = KEY_B; iPlaintext = PT_B;
            end else begin
                iKey       = {$urandom(), $urandom(), $urandom(), $urandom()};
                iPlaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL second_accept_oReady got=%b exp=0", oReady); end
        iValid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (oValid) begin
                lat = n;
                break;
            end
        end
        checks++; if (lat !== 10) begin errors++; $display("FAIL second_latency got=%0d exp=10", lat); end
        checks++; if (oCiphertext !== CT_B) begin errors++; $display("FAIL second_ct got=%h exp=%h", oCiphertext, CT_B); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL second_release_oReady got=%b exp=1", oReady); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        iKey = KEY_C; iPlaintext = PT_C; iValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iValid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL midreset_oValid got=%b exp=0", oValid); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL midreset_oReady got=%b exp=1", oReady); end
        checks++; if (oCiphertext !== 128'h0) begin errors++; $display("FAIL midreset_ct got=%h exp=0", oCiphertext); end
        @(negedge clk);
        rst_n = 1'b1;
        iReady = 1'b1;
        startBlock(KEY_B, PT_B, lat);
        checks++; if (lat !== 10) begin errors++; $display("FAIL after_reset_latency got=%0d exp=10", lat); end
        checks++; if (oCiphertext !== CT_B) begin errors++; $display("FAIL after_reset_ct got=%h exp=%h", oCiphertext, CT_B); end
    endtask

    task automatic test_zeroize;
        @(posedge clk);
        @(negedge clk);
        checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL post_hs_oValid got=%b exp=0", oValid); end
`ifdef AES_ENC_ZEROIZE_EN
        checks++; if (oCiphertext !== 128'h0) begin errors++; $display("FAIL zeroize_ct got=%h exp=0", oCiphertext); end
        checks++; if (dut.stateReg !== 128'h0) begin errors++; $display("FAIL zeroize_state got=%h exp=0", dut.stateReg); end
        checks++; if (dut.keyReg !== 128'h0) begin errors++; $display("FAIL zeroize_key got=%h exp=0", dut.keyReg); end
        checks++; if (dut.rcon !== 8'h0) begin errors++; $display("FAIL zeroize_rcon got=%h exp=0", dut.rcon); end
`else
        checks++; if (oCiphertext !== CT_B) begin errors++; $display("FAIL retain_ct got=%h exp=%h", oCiphertext, CT_B); end
`endif
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_back_pressure();
        test_busy_rejection();
        test_reset_mid();
        test_zeroize();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_encryp_iter.md
# aes_encryp_iter

Iterative AES-128 encryption core: the encrypt-direction counterpart to the team's unrolled AES-128 decryption pipeline, trading throughput for area. It accepts one 128-bit plaintext and key per valid/ready handshake and expands round keys on the fly, one per cycle. It executes the ten FIPS-197 rounds over ten cycles on a single round datapath, then presents the ciphertext under a valid/ready handshake. Its output feeds the decryption pipeline in loopback tests and any link-layer consumer.

## Interface
- No parameters. Key size is fixed at 128 bits and round count at 10.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iValid  in  1  iKey/iPlaintext valid.
- oReady  out  1  core can accept a block; reset value 1.
- iKey  in  128  cipher key; bits [127:120] are key byte 0.
- iPlaintext  in  128  plaintext; bits [127:120] are state byte s(0,0); column-major as in FIPS-197.
- oValid  out  1  oCiphertext valid; reset value 0.
- iReady  in  1  downstream accepts ciphertext.
- oCiphertext  out  128  ciphertext, same byte order; reset value 0.

## Operation
- FSM states and transitions:
  - IDLE → ROUND on iValid && oReady. Accept: state register ← iPlaintext ^ iKey; key register ← iKey; rcon ← 8'h01; rnd ← 1.
  - ROUND: each cycle computes the next round key from the key register and rcon.
    - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
    - State ← MixColumns(ShiftRows(SubBytes(state))) ^ key'; MixColumns is omitted when rnd == 10.
    - Key register ← key'; rcon ← xtime(rcon), i.e. {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00); rnd ← rnd+1.
    - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
  - ROUND → DONE after the round with rnd == 10.
  - DONE: oValid = 1 and oCiphertext = state register. DONE → IDLE on iReady.
- oReady = 1 only in IDLE. iValid is ignored in ROUND and DONE. Inputs are sampled only on the accept edge and may change afterwards.
- rnd is a 4-bit counter. Values 0 and 11–15 are unreachable; if entered, the FSM returns to IDLE.
- Reset asserted mid-operation: the in-flight block is discarded. State goes to IDLE, oReady = 1, oValid = 0, oCiphertext = 0.

## Timing
- Accept edge e0. The round with rnd == 1 executes at edge e0+1, and so on. The round with rnd == 10 executes at edge e0+10; oValid is high from e0+10.
- Latency is 10 cycles from the accept edge to oValid.
- Output handshake at edge e1 (oValid && iReady): oValid falls and oReady rises after e1. The earliest next accept is e1+1.
- Minimum block period is 12 cycles. There is no input/output overlap.
- While oValid = 1 and iReady = 0, oCiphertext and oValid hold stable indefinitely.
- oReady and oValid are registered-state decodes only. There is no combinational path from iValid/iReady to them.

## Configuration
- AES_ENC_ZEROIZE_EN defined:
  - On the output handshake edge, the state, key and rcon registers are cleared to 0.
  - oCiphertext is gated to 0 whenever oValid = 0.
- Not defined:
  - Registers retain their values after the output handshake.
  - oCiphertext shows the raw state register at all times and is meaningful only while oValid = 1.

## Structure
- Shared package aes_pkg holds:
  - S-box constant table and sbox() function.
  - xtime() and MixColumns column function.
  - FSM state typedef (IDLE, ROUND, DONE).
  - Rcon initial value 8'h01 and reduction constant 8'h1b.
- One sub-module, aes_enc_round: purely combinational, taking state, round key and an iLast flag (skip MixColumns) and producing the next state.
- Key expansion stays inline in the top level.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → ct 3925841d02dc09fbdc118597196a0b32, with oValid exactly 10 cycles after accept.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: hold iReady = 0 for 5 cycles after oValid → oValid and ct stay stable. Then iReady = 1 → oReady = 1 the next cycle.
- Busy rejection: iValid held high with changing data during ROUND → no second accept; first ct is correct. Second block accepted 12 cycles after the first.
- Reset at round 5 → oValid = 0, oReady = 1, oCiphertext = 0 immediately. A new App. B block then yields the correct ct.
- With AES_ENC_ZEROIZE_EN: after the output handshake, oCiphertext = 0 and internal state = 0. Without it, oCiphertext still shows 3925841d…0b32.
